conway_board_reader: RTL and testbench

CONWAY_BOARD_READER -- requirements
Module: conway_board_reader

---
 rtl/conway_board_reader_if.sv | 44 ++++
 rtl/conway_board_reader.sv | 188 ++++++++++++++++++
 tb/tb_conway_board_reader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/conway_board_reader_if.sv
// Row-streaming bus between the Conway board reader and its consumer.
// Optional popcount outputs appear only when CONWAY_READER_POPCOUNT_EN is defined.
interface conway_board_reader_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef CONWAY_READER_POPCOUNT_EN
    localparam int RA_W  = $clog2(COLS + 1);
    localparam int TA_W  = $clog2(ROWS * COLS + 1);
`endif

    logic                   ena;
    logic [ROWS*COLS-1:0]   cells;
    logic                   clear;
    logic                   row_ready;
    logic                   row_valid;
    logic [COLS-1:0]        row_data;
    logic [IDX_W-1:0]       row_idx;
    logic                   row_last;
    logic                   busy;
    logic                   overrun;
    logic [15:0]            gen_count;
`ifdef CONWAY_READER_POPCOUNT_EN
    logic [RA_W-1:0]        row_alive;
    logic [TA_W-1:0]        total_alive;
`endif

    modport master (
        output ena, cells, clear, row_ready,
        input  row_valid, row_data, row_idx, row_last, busy, overrun, gen_count
`ifdef CONWAY_READER_POPCOUNT_EN
        , input row_alive, total_alive
`endif
    );

    modport slave (
        input  ena, cells, clear, row_ready,
        output row_valid, row_data, row_idx, row_last, busy, overrun, gen_count
`ifdef CONWAY_READER_POPCOUNT_EN
        , output row_alive, total_alive
`endif
    );
endinterface

// File: rtl/conway_board_reader.sv
// Conway board reader: on a generation tick, snapshots the whole board into a
// shadow register and streams it out one row per valid/ready transfer.
// Ticks arriving mid-stream are dropped and flagged on the sticky overrun bit.
// Optional feature macro: CONWAY_READER_POPCOUNT_EN adds row_alive/total_alive.
module conway_board_reader #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conway_board_reader_if.slave bus
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
`ifdef CONWAY_READER_POPCOUNT_EN
    localparam int RA_W  = $clog2(COLS + 1);
    localparam int TA_W  = $clog2(ROWS * COLS + 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Extract row i of a board image.
    function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] img,
                                               input logic [IDX_W-1:0]     i);
        return img[int'(i)*COLS +: COLS];
    endfunction

`ifdef CONWAY_READER_POPCOUNT_EN
    // Live-cell count of one row.
    function automatic logic [RA_W-1:0] row_popcount(input logic [COLS-1:0] v);
        logic [RA_W-1:0] cnt;
        cnt = {RA_W{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            cnt = cnt + RA_W'(v[i]);
        end
        return cnt;
    endfunction

    // Live-cell count of the whole board.
    function automatic logic [TA_W-1:0] board_popcount(input logic [ROWS*COLS-1:0] v);
        logic [TA_W-1:0] cnt;
        cnt = {TA_W{1'b0}};
        for (int i = 0; i < ROWS * COLS; i++) begin
            cnt = cnt + TA_W'(v[i]);
        end
        return cnt;
    endfunction
`endif

    logic [1:0]           rst_sync_r;
    logic                 rst_n_s;
    state_t               state_r;
    logic [ROWS*COLS-1:0] shadow_r;
    logic [COLS-1:0]      row_data_r;
    logic [IDX_W-1:0]     row_idx_r;
    logic                 row_last_r;
    logic                 row_valid_r;
    logic                 busy_r;
    logic                 overrun_r;
    logic [15:0]          gen_count_r;
`ifdef CONWAY_READER_POPCOUNT_EN
    logic [RA_W-1:0]      row_alive_r;
    logic [TA_W-1:0]      total_alive_r;
`endif

    logic                 transfer_s;
    logic                 final_s;
    logic                 accept_s;
    logic                 drop_s;
    logic [IDX_W-1:0]     next_idx_s;
    logic [COLS-1:0]      next_row_s;

    // A tick is only taken when idle or when the last row leaves this very cycle;
    // any other tick while streaming is lost.
    assign transfer_s = row_valid_r & bus.row_ready;
    assign final_s    = transfer_s & row_last_r;
    assign accept_s   = bus.ena & ((state_r == ST_IDLE) | final_s);
    assign drop_s     = bus.ena & (state_r == ST_SEND) & ~final_s;
    assign next_idx_s = row_idx_r + IDX_W'(1);
    assign next_row_s = row_of(shadow_r, next_idx_s);

    // Reset synchroniser: assertion propagates at once, release is aligned to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Sticky overrun flag: a dropped tick wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.clear) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Streaming FSM with snapshot capture and registered row outputs.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r       <= ST_IDLE;
            shadow_r      <= {(ROWS*COLS){1'b0}};
            row_data_r    <= {COLS{1'b0}};
            row_idx_r     <= {IDX_W{1'b0}};
            row_last_r    <= 1'b0;
            row_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            gen_count_r   <= 16'd0;
`ifdef CONWAY_READER_POPCOUNT_EN
            row_alive_r   <= {RA_W{1'b0}};
            total_alive_r <= {TA_W{1'b0}};
`endif
        end else if (accept_s) begin
            // Row 0 is loaded straight from the captured image, i.e. exactly
            // what shadow_r holds from the next cycle on.
            state_r       <= ST_SEND;
            shadow_r      <= bus.cells;
            row_data_r    <= bus.cells[COLS-1:0];
            row_idx_r     <= {IDX_W{1'b0}};
            row_last_r    <= (LAST_IDX == {IDX_W{1'b0}});
            row_valid_r   <= 1'b1;
            busy_r        <= 1'b1;
            gen_count_r   <= gen_count_r + 16'd1;
`ifdef CONWAY_READER_POPCOUNT_EN
            row_alive_r   <= row_popcount(bus.cells[COLS-1:0]);
            total_alive_r <= board_popcount(bus.cells);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_IDLE;
                    row_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                ST_SEND: begin
                    if (final_s) begin
                        state_r     <= ST_IDLE;
                        row_idx_r   <= {IDX_W{1'b0}};
                        row_last_r  <= 1'b0;
                        row_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (transfer_s) begin
                        row_idx_r   <= next_idx_s;
                        row_data_r  <= next_row_s;
                        row_last_r  <= (next_idx_s == LAST_IDX);
`ifdef CONWAY_READER_POPCOUNT_EN
                        row_alive_r <= row_popcount(next_row_s);
`endif
                    end else begin
                        row_idx_r   <= row_idx_r;
                        row_data_r  <= row_data_r;
                        row_last_r  <= row_last_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    row_idx_r   <= {IDX_W{1'b0}};
                    row_last_r  <= 1'b0;
                    row_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row_valid   = row_valid_r;
    assign bus.row_data    = row_data_r;
    assign bus.row_idx     = row_idx_r;
    assign bus.row_last    = row_last_r;
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;
    assign bus.gen_count   = gen_count_r;
`ifdef CONWAY_READER_POPCOUNT_EN
    assign bus.row_alive   = row_alive_r;
    assign bus.total_alive = total_alive_r;
`endif
endmodule

// File: tb/tb_conway_board_reader.sv
// Directed, table-driven bench for conway_board_reader at ROWS=4, COLS=4.
module tb_conway_board_reader;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic clk;
    logic rst;

    conway_board_reader_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    conway_board_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [15:0] cells;
        logic        ready;
        logic        clear;
        logic        e_valid;
        logic [3:0]  e_data;
        logic [1:0]  e_idx;
        logic        e_last;
        logic        e_busy;
        logic        e_ovr;
        logic [15:0] e_gen;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ena, input logic [15:0] cells, input logic ready,
                       input logic clear, input logic v, input logic [3:0] d,
                       input logic [1:0] idx, input logic last, input logic b,
                       input logic ovr, input logic [15:0] gen);
        vec_t t;
        t.ena = ena; t.cells = cells; t.ready = ready; t.clear = clear;
        t.e_valid = v; t.e_data = d; t.e_idx = idx; t.e_last = last;
        t.e_busy = b; t.e_ovr = ovr; t.e_gen = gen;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic ena, input logic [15:0] cells, input logic ready,
                         input logic clear);
        bus.ena       = ena;
        bus.cells     = cells;
        bus.row_ready = ready;
        bus.clear     = clear;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        //        ena   cells     rdy   clr   valid data idx   last  busy  ovr   gen
        // basic stream, A5C3 -> rows 3,C,5,A
        add(1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 4'h3, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hC, 2'd1, 1'b0, 1'b1, 1'b0, 16'd1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 2'd2, 1'b0, 1'b1, 1'b0, 16'd1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hA, 2'd3, 1'b1, 1'b1, 1'b0, 16'd1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        // backpressure: ready toggles
        add(1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 4'h3, 2'd0, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h3, 2'd0, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hC, 2'd1, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'hC, 2'd1, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 2'd2, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h5, 2'd2, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hA, 2'd3, 1'b1, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'hA, 2'd3, 1'b1, 1'b1, 1'b0, 16'd2);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd2);
        // overrun: 1234 -> rows 4,3,2,1; tick during row 1 dropped; clear+drop keeps flag
        add(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 4'h4, 2'd0, 1'b0, 1'b1, 1'b0, 16'd3);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h3, 2'd1, 1'b0, 1'b1, 1'b0, 16'd3);
        add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'h2, 2'd2, 1'b0, 1'b1, 1'b1, 16'd3);
        add(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'h2, 2'd2, 1'b0, 1'b1, 1'b1, 16'd3);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h1, 2'd3, 1'b1, 1'b1, 1'b1, 16'd3);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
        // back-to-back: 5A0F -> F,0,A,5 then 8421 accepted on the last transfer
        add(1'b1, 16'h5A0F, 1'b1, 1'b0, 1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hA, 2'd2, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 2'd3, 1'b1, 1'b1, 1'b0, 16'd4);
        add(1'b1, 16'h8421, 1'b1, 1'b0, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1, 1'b0, 16'd5);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h2, 2'd1, 1'b0, 1'b1, 1'b0, 16'd5);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h4, 2'd2, 1'b0, 1'b1, 1'b0, 16'd5);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1, 1'b0, 16'd5);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd5);

        // reset and release; let the synchroniser settle
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.row_valid), 32'd0);
        check("reset_gen",   32'(bus.gen_count), 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_release_valid", 32'(bus.row_valid), 32'd0);
        check("post_release_busy",  32'(bus.busy), 32'd0);
        check("post_release_data",  32'(bus.row_data), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].ena, vecs[i].cells, vecs[i].ready, vecs[i].clear);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.row_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(vecs[i].e_busy));
            check($sformatf("v%0d_ovr", i),   32'(bus.overrun),   32'(vecs[i].e_ovr));
            check($sformatf("v%0d_gen", i),   32'(bus.gen_count), 32'(vecs[i].e_gen));
            check($sformatf("v%0d_last", i),  32'(bus.row_last),  32'(vecs[i].e_last));
            check($sformatf("v%0d_idx", i),   32'(bus.row_idx),   32'(vecs[i].e_idx));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_data", i), 32'(bus.row_data), 32'(vecs[i].e_data));
            end
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        // reset mid-stream: outputs clear without a clock edge
        drive(1'b1, 16'hA5C3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("mid_pre_valid", 32'(bus.row_valid), 32'd1);
        check("mid_pre_data",  32'(bus.row_data), 32'hC);
        rst = 1'b0;
        #1;
        check("async_valid", 32'(bus.row_valid), 32'd0);
        check("async_data",  32'(bus.row_data), 32'd0);
        check("async_idx",   32'(bus.row_idx), 32'd0);
        check("async_busy",  32'(bus.busy), 32'd0);
        check("async_gen",   32'(bus.gen_count), 32'd0);
        check("async_ovr",   32'(bus.overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("no_stream_%0d", k), 32'(bus.row_valid), 32'd0);
        end
        drive(1'b1, 16'h00F0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("restart_valid", 32'(bus.row_valid), 32'd1);
        check("restart_data",  32'(bus.row_data), 32'h0);
        check("restart_gen",   32'(bus.gen_count), 32'd1);
        bus.row_ready = 1'b1;
        @(posedge clk);
        #1;
        check("restart_row1", 32'(bus.row_data), 32'hF);
        repeat (3) @(posedge clk);
        #1;
        check("restart_done", 32'(bus.row_valid), 32'd0);

`ifdef CONWAY_READER_POPCOUNT_EN
        // popcount: full board then empty board
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("pc_full_row%0d", r), 32'(bus.row_alive), 32'd4);
            check($sformatf("pc_full_tot%0d", r), 32'(bus.total_alive), 32'd16);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("pc_empty_row", 32'(bus.row_alive), 32'd0);
        check("pc_empty_tot", 32'(bus.total_alive), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
